// File: rtl/mover_pkg.sv
// Shared definitions for the mover block: FSM state encoding and the
// address stride rule (one item's worth of bytes per step).
package mover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int BYTE_BITS      = 8;
    localparam int DEFAULT_STRIDE = 16;

    // Byte stride between consecutive items of the given data width.
    function automatic int stride_bytes(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/mover.sv
// Single-channel item mover: reads N items from a source address range and
// writes them to a destination range, one read then one write per item.
module mover
    import mover_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  MOVE_START,
    input  logic [7:0]            MOVE_NUM,
    input  logic [ADDR_WIDTH-1:0] SOURCE_ADDR,
    input  logic [ADDR_WIDTH-1:0] DEST_ADDR,
    output logic                  MOVE_DONE,
    output logic                  RD_START,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  RD_DONE,
    output logic                  WR_START,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_DONE
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(stride_bytes(DATA_WIDTH));

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   src_reg, src_next;
    logic [ADDR_WIDTH-1:0]   dst_reg, dst_next;
    logic [7:0]              num_reg, num_next;
    logic [7:0]              idx_reg, idx_next;
    logic [7:0]              idx_inc;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
    logic                    rd_start_reg, rd_start_next;
    logic                    wr_start_reg, wr_start_next;
    logic                    move_done_reg, move_done_next;

    assign idx_inc = idx_reg + 8'd1;

    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            state_reg     <= ST_IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            num_reg       <= '0;
            idx_reg       <= '0;
            rd_addr_reg   <= '0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_start_reg  <= 1'b0;
            wr_start_reg  <= 1'b0;
            move_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            num_reg       <= num_next;
            idx_reg       <= idx_next;
            rd_addr_reg   <= rd_addr_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            rd_start_reg  <= rd_start_next;
            wr_start_reg  <= wr_start_next;
            move_done_reg <= move_done_next;
        end
    end

    // Outputs are computed on the transition into a state so that every
    // pulse and address is a flop output during the state it belongs to.
    // src_reg/dst_reg track the current item's addresses (base + stride*i).
    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        num_next       = num_reg;
        idx_next       = idx_reg;
        rd_addr_next   = rd_addr_reg;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        rd_start_next  = 1'b0;
        wr_start_next  = 1'b0;
        move_done_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (MOVE_START) begin
                    src_next = SOURCE_ADDR;
                    dst_next = DEST_ADDR;
                    num_next = MOVE_NUM;
                    idx_next = 8'd0;
                    if (MOVE_NUM == 8'd0) begin
                        state_next     = ST_DONE;
                        move_done_next = 1'b1;
                    end else begin
                        state_next    = ST_RD_REQ;
                        rd_start_next = 1'b1;
                        rd_addr_next  = SOURCE_ADDR;
                    end
                end
            end
            ST_RD_REQ: begin
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (RD_DONE) begin
                    state_next    = ST_WR_REQ;
                    wr_start_next = 1'b1;
                    wr_addr_next  = dst_reg;
                    wr_data_next  = RD_DATA;
                end
            end
            ST_WR_REQ: begin
                state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (WR_DONE) begin
                    idx_next = idx_inc;
                    src_next = src_reg + STRIDE;
                    dst_next = dst_reg + STRIDE;
                    if (idx_inc == num_reg) begin
                        state_next     = ST_DONE;
                        move_done_next = 1'b1;
                    end else begin
                        state_next    = ST_RD_REQ;
                        rd_start_next = 1'b1;
                        rd_addr_next  = src_reg + STRIDE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign MOVE_DONE = move_done_reg;
    assign RD_START  = rd_start_reg;
    assign RD_ADDR   = rd_addr_reg;
    assign WR_START  = wr_start_reg;
    assign WR_ADDR   = wr_addr_reg;
    assign WR_DATA   = wr_data_reg;

endmodule

// File: tb/tb_mover.sv
// Self-checking bench for mover: a memory responder with random latency and
// spurious done pulses, and a transfer-level model of expected reads/writes.
module tb_mover;

    localparam int DW = 128;
    localparam int AW = 32;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          MOVE_START;
    logic [7:0]    MOVE_NUM;
    logic [AW-1:0] SOURCE_ADDR;
    logic [AW-1:0] DEST_ADDR;
    logic          MOVE_DONE;
    logic          RD_START;
    logic [AW-1:0] RD_ADDR;
    logic [DW-1:0] RD_DATA;
    logic          RD_DONE;
    logic          WR_START;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          WR_DONE;

    mover #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .MOVE_START(MOVE_START), .MOVE_NUM(MOVE_NUM),
        .SOURCE_ADDR(SOURCE_ADDR), .DEST_ADDR(DEST_ADDR), .MOVE_DONE(MOVE_DONE),
        .RD_START(RD_START), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_DONE(RD_DONE),
        .WR_START(WR_START), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_DONE(WR_DONE)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory contents: each word is its own address replicated, optionally salted.
    logic [DW-1:0] salt = '0;
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {4{a}} ^ salt;
    endfunction

    int  cyc = 0;
    int  fixed_lat = 4;
    bit  spur_en = 1'b0;
    int  last_wr_done_cyc = -1;

    // Monitor logs
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_a_q[$];
    logic [DW-1:0] wr_d_q[$];
    int  done_n = 0;
    int  done_cyc = -1;
    int  first_rd_cyc = -1;
    bit  rd_busy = 1'b0;
    bit  wr_busy = 1'b0;

    function automatic int pick_lat();
        return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
    endfunction

    // Responder: drives done pulses on the falling edge.
    initial begin
        bit            rp, wp;
        int            rc, wc;
        logic [AW-1:0] ra;
        rp = 0; wp = 0; rc = 0; wc = 0; ra = '0;
        RD_DONE = 0; WR_DONE = 0; RD_DATA = '0;
        forever begin
            @(negedge ACLK);
            RD_DONE = 0;
            WR_DONE = 0;
            if (rp) begin
                rc--;
                if (rc == 0) begin
                    RD_DONE = 1;
                    RD_DATA = mem_data(ra);
                    rp = 0;
                end
            end else if (RD_START) begin
                rp = 1; ra = RD_ADDR; rc = pick_lat();
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                RD_DONE = 1;
                RD_DATA = {$urandom, $urandom, $urandom, $urandom};
            end
            if (wp) begin
                wc--;
                if (wc == 0) begin
                    WR_DONE = 1;
                    wp = 0;
                    last_wr_done_cyc = cyc;
                end
            end else if (WR_START) begin
                wp = 1; wc = pick_lat();
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                WR_DONE = 1;
            end
        end
    end

    // Monitor: samples registered outputs just after the rising edge.
    initial begin
        forever begin
            @(posedge ACLK);
            cyc++;
            #1;
            if (ARESETN) begin
                rd_busy = 0;
                wr_busy = 0;
            end
            if (RD_DONE && rd_busy) begin
                check("rd_addr_hold", RD_ADDR, rd_q[$]);
                rd_busy = 0;
            end
            if (WR_DONE && wr_busy) begin
                check("wr_hold", {WR_ADDR, WR_DATA}, {wr_a_q[$], wr_d_q[$]});
                wr_busy = 0;
            end
            if (RD_START) begin
                check("rd_overlap", {rd_busy, wr_busy}, 2'b00);
                rd_q.push_back(RD_ADDR);
                if (rd_q.size() == 1) first_rd_cyc = cyc;
                rd_busy = 1;
            end
            if (WR_START) begin
                check("wr_overlap", {rd_busy, wr_busy}, 2'b00);
                wr_a_q.push_back(WR_ADDR);
                wr_d_q.push_back(WR_DATA);
                wr_busy = 1;
            end
            if (MOVE_DONE) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
        done_n = 0; done_cyc = -1; first_rd_cyc = -1;
    endtask

    task automatic do_move(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [7:0] n, input bit mid);
        int st;
        clear_logs();
        @(negedge ACLK);
        SOURCE_ADDR = src; DEST_ADDR = dst; MOVE_NUM = n; MOVE_START = 1;
        st = cyc;
        @(negedge ACLK);
        MOVE_START = 0;
        SOURCE_ADDR = $urandom; DEST_ADDR = $urandom; MOVE_NUM = 8'($urandom_range(1, 255));
        for (int k = 0; k < 20000 && done_n == 0; k++) begin
            @(negedge ACLK);
            MOVE_START = mid && (k == 2 || k == 4);
            if (MOVE_START) begin
                SOURCE_ADDR = $urandom; DEST_ADDR = $urandom;
                MOVE_NUM = 8'($urandom_range(1, 255));
            end
        end
        MOVE_START = 0;
        check("done_timeout", 1'(done_n != 0), 1'b1);
        repeat (6) @(negedge ACLK);
        check("done_count", done_n, 1);
        check("rd_count", rd_q.size(), n);
        check("wr_count", wr_a_q.size(), n);
        for (int k = 0; k < int'(n) && k < rd_q.size() && k < wr_a_q.size(); k++) begin
            logic [AW-1:0] sa, da;
            sa = src + AW'(k * (DW / 8));
            da = dst + AW'(k * (DW / 8));
            check("rd_addr", rd_q[k], sa);
            check("wr_addr", wr_a_q[k], da);
            check("wr_data", wr_d_q[k], mem_data(sa));
        end
        if (n == 0) begin
            check("done_lat0", done_cyc, st + 1);
        end else begin
            check("rd_lat", first_rd_cyc, st + 1);
            check("done_lat", done_cyc, last_wr_done_cyc + 1);
        end
        $display("move src=%08h dst=%08h n=%0d reads=%0d writes=%0d dones=%0d",
                 src, dst, n, rd_q.size(), wr_a_q.size(), done_n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rd_in_reset;
        ARESETN = 1; MOVE_START = 0; MOVE_NUM = 0; SOURCE_ADDR = 0; DEST_ADDR = 0;

        // Long reset with start requests that must be ignored
        clear_logs();
        for (int k = 0; k < 200; k++) begin
            @(negedge ACLK);
            MOVE_START = (k % 7 == 3);
            MOVE_NUM = 8'd5; SOURCE_ADDR = 32'h1234_5670;
        end
        check("reset_outputs", {MOVE_DONE, RD_START, WR_START, RD_ADDR, WR_ADDR, WR_DATA}, '0);
        rd_in_reset = rd_q.size();
        check("reset_no_rd", rd_in_reset, 0);
        check("reset_no_done", done_n, 0);
        MOVE_START = 0;
        @(negedge ACLK);
        ARESETN = 0;
        repeat (3) @(negedge ACLK);

        fixed_lat = 4; salt = '0;
        do_move(32'h1000_0000, 32'h2000_0000, 8'd4, 1'b0);
        fixed_lat = 0;
        do_move(32'h3000_0000, 32'h4000_0000, 8'd10, 1'b0);
        do_move(32'h5000_0000, 32'h6000_0000, 8'd0, 1'b0);
        fixed_lat = 3;
        do_move(32'hFFFF_FFF0, 32'h7000_0000, 8'd2, 1'b1);

        // Reset while waiting for read data; the late RD_DONE must be ignored
        clear_logs();
        fixed_lat = 6;
        @(negedge ACLK);
        SOURCE_ADDR = 32'h8000_0000; DEST_ADDR = 32'h9000_0000; MOVE_NUM = 8'd3; MOVE_START = 1;
        @(negedge ACLK);
        MOVE_START = 0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);
        check("midreset_outputs", {MOVE_DONE, RD_START, WR_START, RD_ADDR, WR_ADDR, WR_DATA}, '0);
        @(negedge ACLK);
        ARESETN = 0;
        repeat (20) @(negedge ACLK);
        check("midreset_no_done", done_n, 0);
        check("midreset_no_wr", wr_a_q.size(), 0);
        $display("aborted move reads=%0d writes=%0d dones=%0d", rd_q.size(), wr_a_q.size(), done_n);
        fixed_lat = 2;
        do_move(32'hA000_0000, 32'hB000_0000, 8'd1, 1'b0);

        // Randomized moves with spurious done pulses
        spur_en = 1'b1;
        fixed_lat = 0;
        for (int t = 0; t < 8; t++) begin
            salt = {$urandom, $urandom, $urandom, $urandom};
            do_move($urandom, $urandom, 8'($urandom_range(1, 12)), t[0]);
        end
        fixed_lat = 1;
        do_move(32'hFFFF_F000, $urandom, 8'd255, 1'b1);
        spur_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mover.md
MOVER -- requirements
Module: mover

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 128, item data width; ADDR_WIDTH, default 32, byte-address width.
REQ-002 ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 ARESETN  input  1  reset, synchronous and active-high (1 = reset), sampled on ACLK rising edge.
REQ-004 MOVE_START  input  1  start request; sampled only in IDLE.
REQ-005 MOVE_NUM  input  8  number of items to move (0..255).
REQ-006 SOURCE_ADDR  input  ADDR_WIDTH  first read byte address.
REQ-007 DEST_ADDR  input  ADDR_WIDTH  first write byte address.
REQ-008 MOVE_DONE  output  1  one-cycle completion pulse.
REQ-009 RD_START  output  1  one-cycle read request pulse.
REQ-010 RD_ADDR  output  ADDR_WIDTH  read address; stable from RD_START until RD_DONE.
REQ-011 RD_DATA  input  DATA_WIDTH  read data; valid in the RD_DONE cycle.
REQ-012 RD_DONE  input  1  read completion pulse.
REQ-013 WR_START  output  1  one-cycle write request pulse.
REQ-014 WR_ADDR  output  ADDR_WIDTH  write address; stable from WR_START until WR_DONE.
REQ-015 WR_DATA  output  DATA_WIDTH  write data; stable from WR_START until WR_DONE.
REQ-016 WR_DONE  input  1  write completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE; all outputs registered.
REQ-018 IDLE: MOVE_START=1 SHALL latch SOURCE_ADDR, DEST_ADDR, MOVE_NUM and go to RD_REQ, or to DONE if MOVE_NUM=0.
REQ-019 MOVE_START in any state other than IDLE SHALL be ignored; latched operands SHALL not change mid-move.
REQ-020 RD_REQ: RD_START=1 for exactly one cycle; RD_ADDR = src + 16*i (i = item index 0..N-1, modulo 2^ADDR_WIDTH); then RD_WAIT.
REQ-021 RD_WAIT: hold until RD_DONE=1; capture RD_DATA into data register; go to WR_REQ.
REQ-022 WR_REQ: WR_START=1 for exactly one cycle; WR_ADDR = dst + 16*i; WR_DATA = captured data; then WR_WAIT.
REQ-023 WR_WAIT: hold until WR_DONE=1; increment i; if i = N go to DONE, else go to RD_REQ.
REQ-024 DONE: MOVE_DONE=1 for exactly one cycle; return to IDLE.
REQ-025 Address stride SHALL be DATA_WIDTH/8 bytes (16 at default); address arithmetic SHALL wrap silently.
REQ-026 RD_DONE outside RD_WAIT and WR_DONE outside WR_WAIT SHALL be ignored; no timeout (waits indefinitely).
REQ-027 Latency: RD_START SHALL assert in the cycle after MOVE_START is sampled; MOVE_DONE SHALL assert in the cycle after the last WR_DONE is sampled.
REQ-028 Exactly one read and one write SHALL be outstanding at most; reads and writes never overlap.

Reset
REQ-029 ARESETN=1 SHALL force IDLE, i=0, and MOVE_DONE, RD_START, WR_START=0, RD_ADDR, WR_ADDR, WR_DATA=0, in the same clock edge.
REQ-030 Reset mid-move SHALL abort the transfer without MOVE_DONE; pending RD_DONE/WR_DONE after reset SHALL be ignored.

Structure
REQ-031 State encoding and the stride constant SHALL reside in a shared package (mover_pkg); DATA_WIDTH/ADDR_WIDTH stay module parameters.
REQ-032 The block SHALL be a single module with no sub-modules (FSM, index counter, address and data registers).

Verification
REQ-033 Reset held 1 for 200 cycles -> all outputs 0, no RD_START.
REQ-034 src=0x1000_0000, dst=0x2000_0000, NUM=4, memory model returns {4{RD_ADDR}} after 4 cycles -> writes to 0x2000_0000/10/20/30 with data {4{0x1000_0000}}/{4{0x1000_0010}}/{4{0x1000_0020}}/{4{0x1000_0030}}, then one MOVE_DONE pulse.
REQ-035 src=0x3000_0000, dst=0x4000_0000, NUM=10 -> 10 reads 0x3000_0000..0x3000_0090, 10 matching writes 0x4000_0000..0x4000_0090, one MOVE_DONE.
REQ-036 NUM=0 with MOVE_START -> MOVE_DONE one cycle later, no RD_START/WR_START.
REQ-037 MOVE_START pulsed again mid-move, and src=0xFFFF_FFF0 NUM=2 -> second start ignored; second read address wraps to 0x0000_0000.
REQ-038 ARESETN asserted during RD_WAIT, then new move NUM=1 -> no MOVE_DONE for aborted move; new move completes normally.
